// File: rtl/flag_stack.sv
// WIDTH-bit flag register with per-bit set/clear/load and a DEPTH-entry LIFO shadow stack.
// Optional sticky overflow/underflow flags are enabled by defining FLAG_STACK_ERR_EN.
module flag_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SET,
    input  logic [WIDTH-1:0] CLR,
    input  logic [WIDTH-1:0] LD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             PUSH,
    input  logic             POP,
    output logic [WIDTH-1:0] DOUT,
    output logic [CNTW-1:0]  COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF,
    output logic             UNF,
    input  logic             ERR_CLR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] dout_reg, dout_next, dout_upd;
    logic [CNTW-1:0]  count_reg, count_next;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [AW-1:0]    wr_idx, top_idx;
    logic             full, empty, push_ok, pop_ok;

    assign full    = (count_reg == CNTW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = PUSH & ~POP & ~full;
    assign pop_ok  = POP & ~PUSH & ~empty;
    assign wr_idx  = AW'(count_reg);
    assign top_idx = AW'(count_reg - CNTW'(1));

    // Each flag bit resolves its own priority: set over clear over load over hold.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign dout_upd[gi] = SET[gi] ? 1'b1 :
                                  CLR[gi] ? 1'b0 :
                                  LD[gi]  ? DIN[gi] : dout_reg[gi];
        end
    endgenerate

    always_comb begin
        dout_next  = pop_ok ? stack_mem[top_idx] : dout_upd;
        count_next = count_reg;
        if (push_ok)
            count_next = count_reg + CNTW'(1);
        else if (pop_ok)
            count_next = count_reg - CNTW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dout_reg  <= '0;
            count_reg <= '0;
        end else begin
            dout_reg  <= dout_next;
            count_reg <= count_next;
        end
    end

    // Stack entries carry no reset; an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (push_ok)
            stack_mem[wr_idx] <= dout_reg;
    end

`ifdef FLAG_STACK_ERR_EN
    logic ovf_reg, ovf_next, unf_reg, unf_next;

    // An error event in the same cycle as ERR_CLR leaves the flag set.
    assign ovf_next = (PUSH & ~POP & full)  | (ovf_reg & ~ERR_CLR);
    assign unf_next = (POP & ~PUSH & empty) | (unf_reg & ~ERR_CLR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    assign OVF = ovf_reg;
    assign UNF = unf_reg;
`else
    logic err_clr_unused;

    assign err_clr_unused = ERR_CLR;
    assign OVF = 1'b0;
    assign UNF = 1'b0;
`endif

    assign DOUT  = dout_reg;
    assign COUNT = count_reg;
    assign FULL  = full;
    assign EMPTY = empty;

endmodule
